serial_deser: RTL and testbench
===============================

Name: serial_deser

Overview:
- Downstream stage of the single-bit D flip-flop. Consumes its registered serial output, one bit per qualified clock.
- Assembles WIDTH-bit words, LSB first, and presents each word on a valid/ready output port.
- Sits between the bit-sampling flop and any parallel consumer. It adds a bit counter, a word-holding register and overrun detection.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- bit_valid  input  1  qualifies bit_in this cycle.
- bit_in  input  1  serial data bit (the flip-flop's q output).
- dout  output  WIDTH  assembled word; bit 0 is the first bit received.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- parity_err  output  1  error flag for the word on dout; qualified by dout_valid.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, bit count=0, shift register=0, dout=0, dout_valid=0, overrun=0, parity_err=0. Reset overrides all other inputs.
- Reset mid-word discards the partial word. Reset while dout_valid=1 drops the held word; no overrun is reported.
- FSM states are IDLE, SHIFT and PAR. PAR exists only with the optional feature enabled.
- IDLE: a cycle with bit_valid=1 stores the bit at shift position 0, sets count=1 and moves to SHIFT.
- SHIFT: each cycle with bit_valid=1 stores bit_in at position count, then increments count.
  - Cycles with bit_valid=0 hold all state; there is no timeout.
- Word complete: the bit_valid cycle in which count==WIDTH-1.
  - Feature off: the word is committed in that same edge and the FSM returns to IDLE with count=0.
  - Feature on: the FSM moves to PAR instead.
- Commit: dout <= assembled word and dout_valid <= 1, visible on the cycle after the last bit. Latency from last data bit to dout_valid is 1 clock.
- Handshake: dout_valid stays at 1 and dout stays stable until a cycle with dout_ready=1. At that edge dout_valid clears, unless a commit occurs in the same edge.
- Simultaneous commit and accept (dout_valid=1, dout_ready=1, commit this edge): the new word loads, dout_valid stays 1 and overrun stays 0.
- Commit while dout_valid=1 and dout_ready=0:
  - The new word is dropped and the old dout is kept.
  - overrun=1 for exactly one cycle.
  - The FSM still returns to IDLE, so bit alignment is preserved.
- Back-to-back words with no idle cycles are supported. Sustained throughput is one bit per clock.
- dout_ready while dout_valid=0 is ignored.

Optional Feature:
- Macro: SERIAL_DESER_PARITY_EN.
- Defined:
  - After WIDTH data bits, the next bit_valid cycle (state PAR) carries an even-parity bit.
  - The commit happens at that edge, so latency is 1 clock after the parity bit.
  - parity_err <= XOR of all data bits and the parity bit. It is loaded together with dout and held with it.
  - The PAR state obeys the same overrun and simultaneous-event rules as a normal commit.
- Undefined: no PAR state, parity_err is tied to 0 and a word is WIDTH bits long.

Decomposition:
- Package serial_pkg holds:
  - the state enum (IDLE, SHIFT, PAR);
  - the default word width constant;
  - a count-width function (clog2 of WIDTH+1).
- One sub-module, deser_out_slice, is natural. It contains the dout/dout_valid/parity_err holding register, the ready handshake and overrun generation.
- serial_deser keeps the FSM, the bit counter and the shift register.

Test Plan:
- Reset, then bits 1,0,1,1,0,0,1,0 on consecutive cycles with dout_ready=1 -> dout=8'h4D, dout_valid=1 for 1 cycle, one clock after the 8th bit.
- Same word with bit_valid gaps of 3 idle cycles between bits -> identical dout=8'h4D; no early valid.
- dout_ready=0, two full words 8'hA5 then 8'h3C -> dout stays 8'hA5, overrun pulses once at the second commit; ready=1 then clears dout_valid.
- dout_valid=1 with word 8'h11, dout_ready=1 in the same edge as the commit of 8'h22 -> dout=8'h22, dout_valid stays 1, overrun=0.
- rst=1 asserted after 5 of 8 bits, then a full word 8'hFF -> dout=8'hFF exactly; the partial bits are discarded and dout_valid is 0 during reset.
- SERIAL_DESER_PARITY_EN: data 8'h03 with parity bit 0 -> parity_err=0; data 8'h07 with parity bit 0 -> parity_err=1. Commit occurs 1 clock after the parity bit.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state type, default width and count-width helper for serial_deser
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed for a counter that must reach WIDTH (parity slot included).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_out_slice.sv
// rtl/deser_out_slice.sv - output word register with valid/ready handshake and overrun pulse
module deser_out_slice
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic [WIDTH-1:0] commit_word,
  input  logic             commit_perr,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun,
  output logic             parity_err
);

  // Load a committed word when the slot is free or being drained this edge; otherwise drop it and flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!dout_valid || dout_ready) begin
          dout       <= commit_word;
          parity_err <= commit_perr;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_deser.sv
// rtl/serial_deser.sv - LSB-first serial-to-parallel word assembler; optional even parity via SERIAL_DESER_PARITY_EN
module serial_deser
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             commit;
  logic [WIDTH-1:0] commit_word;
  logic             commit_perr;

  // State, bit counter and shift register; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      sreg  <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      sreg  <= sreg_n;
    end
  end

  // Next-state: place each qualified bit at its count position and commit on the last one.
  always_comb begin
    state_n     = state;
    count_n     = count;
    sreg_n      = sreg;
    commit      = 1'b0;
    commit_word = sreg;
    commit_perr = 1'b0;
    case (state)
      IDLE: begin
        if (bit_valid) begin
          sreg_n[0] = bit_in;
          count_n   = CW'(1);
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (count == CW'(i)) sreg_n[i] = bit_in;
          end
          if (count == CW'(WIDTH - 1)) begin
`ifdef SERIAL_DESER_PARITY_EN
            count_n = CW'(WIDTH);
            state_n = PAR;
`else
            commit      = 1'b1;
            commit_word = sreg_n;
            count_n     = '0;
            state_n     = IDLE;
`endif
          end else begin
            count_n = count + CW'(1);
          end
        end
      end
`ifdef SERIAL_DESER_PARITY_EN
      PAR: begin
        if (bit_valid) begin
          commit      = 1'b1;
          commit_word = sreg;
          commit_perr = ^{sreg, bit_in};
          count_n     = '0;
          state_n     = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  deser_out_slice #(.WIDTH(WIDTH)) u_out (
    .clk         (clk),
    .rst         (rst),
    .commit      (commit),
    .commit_word (commit_word),
    .commit_perr (commit_perr),
    .dout_ready  (dout_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

endmodule

// File: tb/tb_serial_deser.sv
// tb/tb_serial_deser.sv - directed self-checking bench for serial_deser
module tb_serial_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         bit_valid = 1'b0;
  logic         bit_in = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         overrun;
  logic         parity_err;

  int total = 0;
  int bad   = 0;
  int early;

  serial_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word LSB first (plus parity bit when enabled); counts valid cycles seen before the final edge.
  task automatic send_word(input logic [W-1:0] w, input int gap, input logic rdy_last,
                           input logic par_flip, output int seen);
    int nb;
    logic b;
    seen = 0;
`ifdef SERIAL_DESER_PARITY_EN
    nb = W + 1;
`else
    nb = W;
`endif
    for (int i = 0; i < nb; i++) begin
      b = (i < W) ? w[i] : (^w ^ par_flip);
      if (i == nb - 1) dout_ready = rdy_last;
      bit_valid = 1'b1;
      bit_in    = b;
      tick();
      bit_valid = 1'b0;
      if (i < nb - 1) begin
        if (dout_valid) seen++;
        for (int g = 0; g < gap; g++) begin
          tick();
          if (dout_valid) seen++;
        end
      end
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    rst = 1'b0;

    // Consecutive bits 1,0,1,1,0,0,1,0 -> 0x4D, valid one clock after last bit, one cycle long
    send_word(8'h4D, 0, 1'b1, 1'b0, early);
    check("t1_early", 32'(early), 32'd0);
    check("t1_valid", 32'(dout_valid), 32'd1);
    check("t1_dout", 32'(dout), 32'h4D);
    tick();
    check("t1_valid_clr", 32'(dout_valid), 32'd0);

    // Same word with 3 idle cycles between bits
    send_word(8'h4D, 3, 1'b1, 1'b0, early);
    check("t2_early", 32'(early), 32'd0);
    check("t2_valid", 32'(dout_valid), 32'd1);
    check("t2_dout", 32'(dout), 32'h4D);
    tick();

    // Overrun: two words with ready low
    dout_ready = 1'b0;
    send_word(8'hA5, 0, 1'b0, 1'b0, early);
    check("t3_dout_a", 32'(dout), 32'hA5);
    check("t3_ovr_a", 32'(overrun), 32'd0);
    send_word(8'h3C, 0, 1'b0, 1'b0, early);
    check("t3_ovr_b", 32'(overrun), 32'd1);
    check("t3_dout_b", 32'(dout), 32'hA5);
    check("t3_valid_b", 32'(dout_valid), 32'd1);
    tick();
    check("t3_ovr_pulse", 32'(overrun), 32'd0);
    check("t3_dout_keep", 32'(dout), 32'hA5);
    dout_ready = 1'b1;
    tick();
    check("t3_valid_clr", 32'(dout_valid), 32'd0);

    // Simultaneous commit and accept
    dout_ready = 1'b0;
    send_word(8'h11, 0, 1'b0, 1'b0, early);
    check("t4_dout_a", 32'(dout), 32'h11);
    send_word(8'h22, 0, 1'b1, 1'b0, early);
    check("t4_dout_b", 32'(dout), 32'h22);
    check("t4_valid", 32'(dout_valid), 32'd1);
    check("t4_ovr", 32'(overrun), 32'd0);
    tick();
    check("t4_valid_clr", 32'(dout_valid), 32'd0);

    // Reset mid-word discards partial bits
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in    = i[0];
      tick();
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("t5_rst_valid", 32'(dout_valid), 32'd0);
    check("t5_rst_dout", 32'(dout), 32'h0);
    rst = 1'b0;
    send_word(8'hFF, 0, 1'b1, 1'b0, early);
    check("t5_early", 32'(early), 32'd0);
    check("t5_dout", 32'(dout), 32'hFF);
    check("t5_valid", 32'(dout_valid), 32'd1);
    check("t5_perr", 32'(parity_err), 32'd0);
    tick();

`ifdef SERIAL_DESER_PARITY_EN
    // Parity: 0x03 with parity 0 is good, 0x07 with parity 0 is bad
    send_word(8'h03, 0, 1'b1, 1'b0, early);
    check("t6_early_a", 32'(early), 32'd0);
    check("t6_dout_a", 32'(dout), 32'h03);
    check("t6_perr_a", 32'(parity_err), 32'd0);
    tick();
    send_word(8'h07, 0, 1'b1, 1'b1, early);
    check("t6_early_b", 32'(early), 32'd0);
    check("t6_dout_b", 32'(dout), 32'h07);
    check("t6_perr_b", 32'(parity_err), 32'd1);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
